wb_retire_trace_fifo: RTL and testbench

Parametrised capture buffer for WB-stage retirement events, feeding the scoreboard reference model.
- Samples one retirement per cycle (pc, instr, result, rd, regwrite, memwrite) and filters it by capture mode.
- Queues qualified events in a first-word-fall-through FIFO that the monitor drains through a valid/ready handshake.
- Tags each entry with a retirement sequence number, so filtered or dropped events show up as gaps.
- Counts overflow drops instead of back-pressuring the core.

---
 rtl/wb_retire_trace_fifo.sv | 162 ++++++++++++++++
 tb/tb_wb_retire_trace_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_retire_trace_fifo.sv
// Capture FIFO for WB-stage retirement events: filters by capture mode, tags each entry with a
// retirement sequence number and counts overflow drops. Optional macro TRACE_TIMESTAMP_EN adds
// a per-entry cycle stamp on out_cycle.
module wb_retire_trace_fifo #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     cap_en,
  input  logic [1:0]               cap_mode,
  input  logic                     ret_valid,
  input  logic [XLEN-1:0]          ret_pc,
  input  logic [31:0]              ret_instr,
  input  logic [XLEN-1:0]          ret_result,
  input  logic [4:0]               ret_rd,
  input  logic                     ret_regwrite,
  input  logic                     ret_memwrite,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [XLEN-1:0]          out_result,
  output logic [4:0]               out_rd,
  output logic                     out_regwrite,
  output logic                     out_memwrite,
  output logic [CNT_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [CNT_W-1:0]         out_cycle
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int unsigned EW = 2 * XLEN + 32 + 5 + 2 + 2 * CNT_W;
`else
  localparam int unsigned EW = 2 * XLEN + 32 + 5 + 2 + CNT_W;
`endif
  localparam logic [AW:0] DepthLvl = (AW + 1)'(DEPTH);

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [CNT_W-1:0] seq_q, seq_d, drop_q, drop_d;
  logic             ovf_q, ovf_d;
`ifdef TRACE_TIMESTAMP_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
`endif

  logic          mode_match, qualify, push, pop, drop, is_full, wr_en;
  logic [EW-1:0] entry_in, head;

  always_comb begin
    mode_match = 1'b0;
    unique case (cap_mode)
      2'd0:    mode_match = 1'b1;
      2'd1:    mode_match = ret_regwrite & (ret_rd != 5'd0);
      2'd2:    mode_match = ret_memwrite;
      default: mode_match = ret_regwrite | ret_memwrite;
    endcase
  end

  always_comb begin
    is_full = (level_q == DepthLvl);
    qualify = ret_valid & cap_en & mode_match;
    pop     = (level_q != '0) & out_ready;
    push    = qualify & (~is_full | pop);
    drop    = qualify & is_full & ~pop;
    // clear swallows a same-cycle push without writing or counting it as a drop
    wr_en   = push & ~clear;
    entry_in = {ret_pc, ret_instr, ret_result, ret_rd, ret_regwrite, ret_memwrite, seq_q
`ifdef TRACE_TIMESTAMP_EN
                , cyc_q
`endif
               };
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    seq_d    = ret_valid ? seq_q + CNT_W'(1) : seq_q;
`ifdef TRACE_TIMESTAMP_EN
    cyc_d    = cyc_q + CNT_W'(1);
`endif
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      drop_d   = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + (AW + 1)'(1);
      else if (pop && !push) level_d = level_q - (AW + 1)'(1);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      cyc_q    <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
`ifdef TRACE_TIMESTAMP_EN
      cyc_q    <= cyc_d;
`endif
    end
  end

  // Storage is reset so the head fields read 0, not X, while the FIFO is empty
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= entry_in;
    end
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
    {out_pc, out_instr, out_result, out_rd, out_regwrite, out_memwrite, out_seq
`ifdef TRACE_TIMESTAMP_EN
     , out_cycle
`endif
    } = head;
    out_valid  = (level_q != '0);
    level      = level_q;
    full       = is_full;
    empty      = (level_q == '0);
    overflow   = ovf_q;
    drop_count = drop_q;
  end

endmodule

// File: tb/tb_wb_retire_trace_fifo.sv
// Directed self-checking bench for wb_retire_trace_fifo (default parameters).
module tb_wb_retire_trace_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1, clear = 1'b0, cap_en = 1'b0, ret_valid = 1'b0, out_ready = 1'b0;
  logic [1:0]  cap_mode = 2'd0;
  logic [31:0] ret_pc = '0, ret_instr = '0, ret_result = '0;
  logic [4:0]  ret_rd = '0;
  logic        ret_regwrite = 1'b0, ret_memwrite = 1'b0;
  logic        out_valid, out_regwrite, out_memwrite, full, empty, overflow;
  logic [31:0] out_pc, out_instr, out_result;
  logic [4:0]  out_rd;
  logic [15:0] out_seq, drop_count;
  logic [4:0]  level;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] out_cycle;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_retire_trace_fifo dut (
    .clk(clk), .reset(reset), .clear(clear), .cap_en(cap_en), .cap_mode(cap_mode),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_result(ret_result),
    .ret_rd(ret_rd), .ret_regwrite(ret_regwrite), .ret_memwrite(ret_memwrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_result(out_result), .out_rd(out_rd), .out_regwrite(out_regwrite),
    .out_memwrite(out_memwrite), .out_seq(out_seq), .level(level), .full(full),
    .empty(empty), .overflow(overflow), .drop_count(drop_count)
`ifdef TRACE_TIMESTAMP_EN
    , .out_cycle(out_cycle)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ret(input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                     input logic mw);
    ret_valid    = 1'b1;
    ret_pc       = pc;
    ret_instr    = pc ^ 32'h0000_0013;
    ret_result   = pc + 32'd1;
    ret_rd       = rd;
    ret_regwrite = rw;
    ret_memwrite = mw;
  endtask

  task automatic idle();
    ret_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_seq", 64'(out_seq), 64'd0);

    // Mode 0 streaming, consumer always ready
    cap_en = 1'b1; cap_mode = 2'd0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ret(32'(i * 4), 5'd1, 1'b1, 1'b0);
      cyc();
      chk("m0_valid", 64'(out_valid), 64'd1);
      chk("m0_pc", 64'(out_pc), 64'(i * 4));
      chk("m0_seq", 64'(out_seq), 64'(i));
      chk("m0_level", 64'(level), 64'd1);
    end
    chk("m0_result", 64'(out_result), 64'h9);
    idle(); cyc();
    chk("m0_drained", 64'(empty), 64'd1);

    // Mode 1: rd=0 filtered, rd=5 captured, no-regwrite filtered; seq now 3
    cap_mode = 2'd1;
    ret(32'h40, 5'd0, 1'b1, 1'b0); cyc();
    chk("m1_rd0_filtered", 64'(empty), 64'd1);
    ret(32'h44, 5'd5, 1'b1, 1'b0); cyc();
    chk("m1_valid", 64'(out_valid), 64'd1);
    chk("m1_rd", 64'(out_rd), 64'd5);
    chk("m1_seq", 64'(out_seq), 64'd4);
    ret(32'h48, 5'd7, 1'b0, 1'b0); cyc();
    chk("m1_norw_filtered", 64'(empty), 64'd1);

    // Mode 2 memwrite only, mode 3 either, cap_en low ignores all
    cap_mode = 2'd2;
    ret(32'h50, 5'd0, 1'b0, 1'b1); cyc();
    chk("m2_seq", 64'(out_seq), 64'd6);
    chk("m2_mw", 64'(out_memwrite), 64'd1);
    ret(32'h54, 5'd3, 1'b1, 1'b0); cyc();
    chk("m2_rw_filtered", 64'(empty), 64'd1);
    cap_mode = 2'd3;
    ret(32'h58, 5'd0, 1'b1, 1'b0); cyc();
    chk("m3_seq", 64'(out_seq), 64'd8);
    cap_en = 1'b0; cap_mode = 2'd0;
    ret(32'h5c, 5'd2, 1'b1, 1'b1); cyc();
    chk("capoff_empty", 64'(empty), 64'd1);
    cap_en = 1'b1;

    // Overflow: 20 qualified events into 16 slots with consumer stalled
    idle(); out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      ret(32'(i * 4), 5'd1, 1'b1, 1'b0);
      cyc();
    end
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_level", 64'(level), 64'd16);
    chk("ovf_drop", 64'(drop_count), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_head_seq", 64'(out_seq), 64'd0);

    // Full with pop and push together: accepted, level unchanged
    out_ready = 1'b1;
    ret(32'h100, 5'd1, 1'b1, 1'b0); cyc();
    chk("fullpp_level", 64'(level), 64'd16);
    chk("fullpp_drop", 64'(drop_count), 64'd4);
    idle();
    for (int i = 1; i < 16; i++) begin
      chk("drain_seq", 64'(out_seq), 64'(i));
      chk("drain_pc", 64'(out_pc), 64'(i * 4));
      cyc();
    end
    chk("drain_last_seq", 64'(out_seq), 64'd20);
    chk("drain_last_pc", 64'(out_pc), 64'h100);
    cyc();
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_ovf_sticky", 64'(overflow), 64'd1);

    // Clear with a same-cycle qualified retirement; seq is 21 here
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ret(32'(32'h200 + i * 4), 5'd1, 1'b1, 1'b0);
      cyc();
    end
    chk("preclr_level", 64'(level), 64'd5);
    clear = 1'b1;
    ret(32'h300, 5'd1, 1'b1, 1'b0); cyc();
    clear = 1'b0; idle();
    chk("clr_empty", 64'(empty), 64'd1);
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_drop", 64'(drop_count), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    ret(32'h304, 5'd1, 1'b1, 1'b0); cyc();
    idle();
    chk("postclr_valid", 64'(out_valid), 64'd1);
    chk("postclr_seq", 64'(out_seq), 64'd27);
    chk("postclr_pc", 64'(out_pc), 64'h304);

`ifdef TRACE_TIMESTAMP_EN
    out_ready = 1'b0;
    do_reset();
    repeat (10) cyc();
    ret(32'h400, 5'd1, 1'b1, 1'b0); cyc();
    idle(); cyc(); cyc();
    ret(32'h404, 5'd1, 1'b1, 1'b0); cyc();
    idle();
    chk("ts_first", 64'(out_cycle), 64'd10);
    out_ready = 1'b1; cyc();
    chk("ts_second", 64'(out_cycle), 64'd13);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
